// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by a 16x-baud sample enable. Produces a byte, a
// one-clock completion strobe and a framing-error flag per received frame.
module uart_rx #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            s_tick,
   input  logic            rx,
   output logic [DBIT-1:0] rx_data,
   output logic            rx_done_tick,
   output logic            frame_err
);

   localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
   localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);
   localparam logic [3:0]    SB_LAST = 4'(SB_TICK - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      s_q, s_d;
   logic [NW-1:0]   n_q, n_d;
   logic [DBIT-1:0] b_q, b_d;
   logic [DBIT-1:0] rx_data_q, rx_data_d;
   logic            done_q, done_d;
   logic            frame_err_q, frame_err_d;
   logic            rx_meta_q, rx_s_q;

   // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         s_q         <= '0;
         n_q         <= '0;
         b_q         <= '0;
         rx_data_q   <= '0;
         done_q      <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         s_q         <= s_d;
         n_q         <= n_d;
         b_q         <= b_d;
         rx_data_q   <= rx_data_d;
         done_q      <= done_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      s_d         = s_q;
      n_d         = n_q;
      b_d         = b_q;
      rx_data_d   = rx_data_q;
      done_d      = 1'b0;
      frame_err_d = frame_err_q;

      unique case (state_q)
         IDLE: begin
            if (!rx_s_q) begin
               state_d = START;
               s_d     = '0;
            end
         end
         START: begin
            // Re-check the line at mid start bit to reject short glitches.
            if (s_tick) begin
               if (s_q == 4'd7) begin
                  if (!rx_s_q) begin
                     state_d = DATA;
                     s_d     = '0;
                     n_d     = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  s_d = s_q + 4'd1;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s_q == 4'd15) begin
                  s_d = '0;
                  b_d = {rx_s_q, b_q[DBIT-1:1]};
                  if (n_q == N_LAST) begin
                     state_d = STOP;
                  end else begin
                     n_d = n_q + NW'(1);
                  end
               end else begin
                  s_d = s_q + 4'd1;
               end
            end
         end
         STOP: begin
            if (s_tick) begin
               if (s_q == SB_LAST) begin
                  rx_data_d   = b_q;
                  frame_err_d = ~rx_s_q;
                  done_d      = 1'b1;
                  state_d     = IDLE;
               end else begin
                  s_d = s_q + 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign rx_data      = rx_data_q;
   assign rx_done_tick = done_q;
   assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are queued as they are sent and checked
// (data, framing flag, tick latency, pulse width) when the receiver reports them.
module tb_uart_rx;

   localparam int BIT_CLK     = 64;
   localparam int LATENCY_TCK = 8 + 16 * 8 + 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       s_tick = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] rx_data;
   logic       rx_done_tick;
   logic       frame_err;

   typedef struct {
      logic [7:0] data;
      logic       ferr;
      int         startTicks;
   } exp_t;

   exp_t       sbq[$];
   int         numCompared = 0;
   int         numMismatched = 0;
   int         tickTotal = 0;
   int         doneCount = 0;
   logic       tickEn = 1'b1;
   logic [1:0] tickDiv = 2'd0;
   logic       prevDone = 1'b0;
   logic [7:0] lastData = 8'h00;

   uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .s_tick       (s_tick),
      .rx           (rx),
      .rx_data      (rx_data),
      .rx_done_tick (rx_done_tick),
      .frame_err    (frame_err)
   );

   always #5 clk = ~clk;

   // Tick source: one clk-wide pulse every 4 clocks, frozen while tickEn is low.
   always @(negedge clk) begin
      if (tickEn) begin
         tickDiv = tickDiv + 2'd1;
         s_tick  = (tickDiv == 2'd0);
      end else begin
         s_tick = 1'b0;
      end
   end

   always @(posedge clk) begin
      if (s_tick) tickTotal = tickTotal + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      numCompared = numCompared + 1;
      if (observed !== expected) begin
         numMismatched = numMismatched + 1;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (prevDone) checkOutput("done_width", {31'd0, rx_done_tick}, 32'd0);
      if (rx_done_tick) begin
         doneCount = doneCount + 1;
         if (sbq.size() == 0) begin
            checkOutput("spurious_done", {31'd0, rx_done_tick}, 32'd0);
         end else begin
            e = sbq.pop_front();
            checkOutput("rx_data", {24'd0, rx_data}, {24'd0, e.data});
            checkOutput("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
            checkOutput("latency", tickTotal - e.startTicks, LATENCY_TCK);
            lastData = e.data;
         end
      end
      prevDone = rx_done_tick;
   end

   // Sends one frame; stallBit >= 0 starves s_tick mid-bit, abortBit >= 0 resets mid-bit.
   task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                                input int stallBit, input int abortBit);
      exp_t e;
      rx = 1'b0;
      repeat (3) @(negedge clk);
      if (abortBit < 0) begin
         e.data       = data;
         e.ferr       = ~stopBit;
         e.startTicks = tickTotal;
         sbq.push_back(e);
      end
      repeat (BIT_CLK - 3) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = data[i];
         if (i == stallBit) begin
            repeat (BIT_CLK / 2) @(negedge clk);
            tickEn = 1'b0;
            repeat (1000) @(negedge clk);
            checkOutput("stall_done", {31'd0, rx_done_tick}, 32'd0);
            checkOutput("stall_data", {24'd0, rx_data}, {24'd0, lastData});
            tickEn = 1'b1;
            repeat (BIT_CLK / 2) @(negedge clk);
         end else if (i == abortBit) begin
            repeat (BIT_CLK / 2) @(negedge clk);
            #2 reset = 1'b1;
            #1;
            checkOutput("abort_data", {24'd0, rx_data}, 32'd0);
            checkOutput("abort_ferr", {31'd0, frame_err}, 32'd0);
            checkOutput("abort_done", {31'd0, rx_done_tick}, 32'd0);
            lastData = 8'h00;
            @(negedge clk);
            rx = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            repeat (2 * BIT_CLK) @(negedge clk);
            return;
         end else begin
            repeat (BIT_CLK) @(negedge clk);
         end
      end
      if (stopBit) begin
         rx = 1'b1;
         repeat (BIT_CLK) @(negedge clk);
      end else begin
         // Release a low stop bit early so the tail is rejected as a glitch.
         rx = 1'b0;
         repeat (48) @(negedge clk);
         rx = 1'b1;
         repeat (3 * BIT_CLK) @(negedge clk);
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (3) @(negedge clk);
      checkOutput("reset_data", {24'd0, rx_data}, 32'd0);
      checkOutput("reset_done", {31'd0, rx_done_tick}, 32'd0);
      checkOutput("reset_ferr", {31'd0, frame_err}, 32'd0);
      reset = 1'b0;
      repeat (BIT_CLK) @(negedge clk);

      applyStimulus(8'hA5, 1'b1, -1, -1);
      repeat (BIT_CLK) @(negedge clk);

      rx = 1'b0;
      repeat (12) @(negedge clk);
      rx = 1'b1;
      repeat (200) @(negedge clk);
      checkOutput("glitch_data", {24'd0, rx_data}, {24'd0, lastData});
      checkOutput("glitch_ferr", {31'd0, frame_err}, 32'd0);

      applyStimulus(8'h3C, 1'b0, -1, -1);
      applyStimulus(8'h81, 1'b1, -1, -1);
      repeat (BIT_CLK) @(negedge clk);

      applyStimulus(8'hFF, 1'b1, -1, 4);
      applyStimulus(8'h5A, 1'b1, -1, -1);
      repeat (BIT_CLK) @(negedge clk);

      applyStimulus(8'h00, 1'b1, -1, -1);
      applyStimulus(8'hFF, 1'b1, -1, -1);
      repeat (BIT_CLK) @(negedge clk);

      applyStimulus(8'hC3, 1'b1, 3, -1);

      for (int k = 0; k < 400 && sbq.size() != 0; k++) @(negedge clk);
      checkOutput("sb_drain", sbq.size(), 32'd0);
      checkOutput("done_count", doneCount, 32'd7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
